spi_shift_register: RTL and testbench
=====================================

SPI_SHIFT_REGISTER -- requirements
Module: spi_shift_register

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as below (clock and reset first).
REQ-002 PClk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 PRESETn  input  1  asynchronous active-low reset.
REQ-004 ss  input  1  slave select, active-low; a transfer SHALL progress only while ss=0.
REQ-005 send_data  input  1  one-cycle load strobe; honoured only in IDLE.
REQ-006 data_mosi  input  8  byte to transmit; sampled when send_data is honoured.
REQ-007 lsbfe, cpol, cpha  input  1 each  bit order (1=LSB first) and SPI mode; latched with data_mosi.
REQ-008 flag_high, flag_low  input  1 each  one-PClk pulses from the baud rate generator marking the sclk rising and falling edge respectively.
REQ-009 miso  input  1  serial data from slave; treated as already synchronous to PClk.
REQ-010 mosi  output  1  serial data to slave.
REQ-011 data_miso  output  8  last completely received byte.
REQ-012 rx_valid  output  1  one-cycle pulse when data_miso is updated.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 States SHALL be IDLE, SHIFT and DONE.
REQ-015 IDLE -> SHIFT SHALL occur when send_data=1 and ss=0; otherwise send_data SHALL be ignored, including when it arrives in SHIFT or DONE.
REQ-016 On load, the block SHALL copy data_mosi to tx_shift, clear rx_shift and the 3-bit bit counter, and latch lsbfe, cpol and cpha.
REQ-017 Edge mapping SHALL use the latched cpol:
- leading = cpol ? flag_low : flag_high
- trailing = cpol ? flag_high : flag_low
REQ-018 If flag_high and flag_low are both 1 in the same cycle, both SHALL be ignored.
REQ-019 cpha=0 behaviour:
- mosi SHALL present the first bit in the cycle after load.
- miso SHALL be sampled on leading pulses.
- tx_shift SHALL advance on trailing pulses.
REQ-020 cpha=1 behaviour:
- tx_shift SHALL advance on leading pulses, with the first leading pulse presenting bit 0 of the sequence.
- miso SHALL be sampled on trailing pulses.
REQ-021 Bit order: lsbfe=1 SHALL transmit tx_shift[0] first and shift right; lsbfe=0 SHALL transmit tx_shift[7] first and shift left.
REQ-022 Received bits SHALL be assembled in the same order, so a peer sending byte B in the same bit order yields data_miso=B.
REQ-023 The bit counter SHALL increment on each sample pulse; the 8th sample (counter wraps 7->0) SHALL move the block SHIFT -> DONE.
REQ-024 Sample and drive pulses arriving after the 8th sample SHALL be ignored.
REQ-025 In DONE, data_miso SHALL be loaded from rx_shift and rx_valid SHALL be 1 for exactly one cycle, followed by DONE -> IDLE.
REQ-026 Latency: the 8th sample pulse in cycle N SHALL give rx_valid=1 in cycle N+1 and busy=0 in cycle N+2.
REQ-027 If ss=1 in SHIFT, the block SHALL abort to IDLE on the next edge: no rx_valid, data_miso unchanged, mosi=0.
REQ-028 The abort SHALL take priority over a simultaneous sample pulse.
REQ-029 In IDLE, mosi SHALL be 0.
REQ-030 flag_* pulses received in IDLE SHALL have no effect.

Reset
REQ-031 PRESETn=0 SHALL immediately force:
- state IDLE
- mosi=0, data_miso=8'h00, rx_valid=0, busy=0
- tx_shift, rx_shift and bit counter to 0
REQ-032 A reset asserted mid-transfer SHALL discard the transfer with no rx_valid, both during reset and after its release.
REQ-033 After reset release, the block SHALL accept send_data on the first PClk edge.

Verification
REQ-034 Mode 0, MSB first: data_mosi=8'hA5, miso bits = 8'h3C MSB-first. Required: mosi sequence 1,0,1,0,0,1,0,1; data_miso=8'h3C; rx_valid one cycle, one cycle after the 8th rising pulse.
REQ-035 Mode 3 (cpol=1, cpha=1), lsbfe=1: data_mosi=8'h81, peer sends 8'h0F LSB-first. Required: mosi 1,0,0,0,0,0,0,1, each bit changing on a flag_low pulse; data_miso=8'h0F.
REQ-036 Abort: ss rises after the 4th sample pulse. Required: busy=0 next cycle, rx_valid never asserted, data_miso keeps its previous value (8'h3C).
REQ-037 Overlapping load: send_data with data_mosi=8'hFF during SHIFT of 8'h00. Required: mosi stays all zeros for the current byte; a new transfer starts only after busy=0.
REQ-038 Reset mid-transfer: PRESETn low after the 3rd bit. Required: all outputs reset values immediately; no rx_valid after release.
REQ-039 Guards: flag_high and flag_low both 1 in one cycle, plus flag pulses while IDLE. Required: bit counter, mosi and state unchanged.

Source files
------------

// File: rtl/spi_shift_register.sv
// SPI master shift register: serialises one byte on mosi while assembling the
// returned miso byte, timed by sclk edge pulses from the baud rate generator.
module spi_shift_register (
    input  logic       PClk,
    input  logic       PRESETn,
    input  logic       ss,
    input  logic       send_data,
    input  logic [7:0] data_mosi,
    input  logic       lsbfe,
    input  logic       cpol,
    input  logic       cpha,
    input  logic       flag_high,
    input  logic       flag_low,
    input  logic       miso,
    output logic       mosi,
    output logic [7:0] data_miso,
    output logic       rx_valid,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t     state, state_next;
    logic [7:0] tx_shift, rx_shift, rx_next;
    logic [2:0] bit_cnt;
    logic       lsbfe_r, cpol_r, cpha_r, drive_en;
    logic       load, hi_ok, lo_ok, leading, trailing, active;
    logic       sample, drive, last_sample;

    always_comb begin
        load        = (state == IDLE) && send_data && !ss;
        hi_ok       = flag_high && !flag_low;
        lo_ok       = flag_low && !flag_high;
        leading     = cpol_r ? lo_ok : hi_ok;
        trailing    = cpol_r ? hi_ok : lo_ok;
        active      = (state == SHIFT) && !ss;
        sample      = active && (cpha_r ? trailing : leading);
        drive       = active && (cpha_r ? leading : trailing);
        last_sample = sample && (bit_cnt == 3'd7);
        rx_next     = lsbfe_r ? {miso, rx_shift[7:1]} : {rx_shift[6:0], miso};
    end

    always_ff @(posedge PClk or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = SHIFT;
            SHIFT:   if (ss) state_next = IDLE;
                     else if (last_sample) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        rx_valid = (state == DONE);
        mosi     = 1'b0;
        if (state == SHIFT && drive_en)
            mosi = lsbfe_r ? tx_shift[0] : tx_shift[7];
    end

    // cpha=1: the first leading edge only enables the output (bit 0),
    // later leading edges advance tx_shift.
    // data_miso takes the completed byte on the 8th sample so it is
    // already valid in the DONE cycle alongside rx_valid.
    always_ff @(posedge PClk or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_shift  <= '0;
            rx_shift  <= '0;
            bit_cnt   <= '0;
            lsbfe_r   <= 1'b0;
            cpol_r    <= 1'b0;
            cpha_r    <= 1'b0;
            drive_en  <= 1'b0;
            data_miso <= '0;
        end else if (load) begin
            tx_shift <= data_mosi;
            rx_shift <= '0;
            bit_cnt  <= '0;
            lsbfe_r  <= lsbfe;
            cpol_r   <= cpol;
            cpha_r   <= cpha;
            drive_en <= !cpha;
        end else begin
            if (drive) begin
                if (drive_en)
                    tx_shift <= lsbfe_r ? {1'b0, tx_shift[7:1]} : {tx_shift[6:0], 1'b0};
                drive_en <= 1'b1;
            end
            if (sample) begin
                rx_shift <= rx_next;
                bit_cnt  <= bit_cnt + 3'd1;
                if (last_sample)
                    data_miso <= rx_next;
            end
        end
    end

endmodule

// File: tb/tb_spi_shift_register.sv
// Directed bench for spi_shift_register: modes 0 and 3, abort, overlapping
// load, reset mid-transfer and flag guards against hand-computed values.
module tb_spi_shift_register;

    logic       PClk = 1'b0;
    logic       PRESETn = 1'b0;
    logic       ss = 1'b1;
    logic       send_data = 1'b0;
    logic [7:0] data_mosi = '0;
    logic       lsbfe = 1'b0, cpol = 1'b0, cpha = 1'b0;
    logic       flag_high = 1'b0, flag_low = 1'b0;
    logic       miso = 1'b0;
    logic       mosi;
    logic [7:0] data_miso;
    logic       rx_valid;
    logic       busy;

    int checks = 0;
    int errors = 0;

    spi_shift_register dut (
        .PClk(PClk), .PRESETn(PRESETn), .ss(ss), .send_data(send_data),
        .data_mosi(data_mosi), .lsbfe(lsbfe), .cpol(cpol), .cpha(cpha),
        .flag_high(flag_high), .flag_low(flag_low), .miso(miso),
        .mosi(mosi), .data_miso(data_miso), .rx_valid(rx_valid), .busy(busy)
    );

    always #5 PClk = ~PClk;

    task automatic step();
        @(posedge PClk);
        #1;
    endtask

    task automatic start(input logic [7:0] d, input logic l, input logic po, input logic ph);
        data_mosi = d; lsbfe = l; cpol = po; cpha = ph;
        ss = 1'b0; send_data = 1'b1;
        step();
        send_data = 1'b0;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        #3;
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b exp 0", mosi); end
        checks++; if (data_miso !== 8'h00) begin errors++; $display("FAIL reset_data_miso got %h exp 00", data_miso); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        step();
        PRESETn = 1'b1;
        step();
    endtask

    task automatic test_mode0();
        logic [7:0] tx, rx;
        tx = 8'hA5; rx = 8'h3C;
        start(tx, 1'b0, 1'b0, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL m0_busy got %b exp 1", busy); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (mosi !== tx[7-i]) begin errors++; $display("FAIL m0_mosi bit%0d got %b exp %b", i, mosi, tx[7-i]); end
            miso = rx[7-i]; flag_high = 1'b1;
            step();
            flag_high = 1'b0;
            if (i < 7) begin
                checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL m0_early_rx_valid bit%0d got %b exp 0", i, rx_valid); end
                flag_low = 1'b1;
                step();
                flag_low = 1'b0;
            end
        end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL m0_rx_valid got %b exp 1", rx_valid); end
        checks++; if (data_miso !== 8'h3C) begin errors++; $display("FAIL m0_data_miso got %h exp 3c", data_miso); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL m0_busy_done got %b exp 1", busy); end
        step();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL m0_rx_valid_len got %b exp 0", rx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL m0_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_abort();
        start(8'hF0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            flag_high = 1'b1; step(); flag_high = 1'b0;
            flag_low = 1'b1; step(); flag_low = 1'b0;
        end
        flag_high = 1'b1; step(); flag_high = 1'b0;
        flag_low = 1'b1; step(); flag_low = 1'b0;
        // abort coincides with what would be the 5th sample
        ss = 1'b1; flag_high = 1'b1;
        step();
        flag_high = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL abort_mosi got %b exp 0", mosi); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL abort_rx_valid cyc%0d got %b exp 0", i, rx_valid); end
            flag_high = (i % 2 == 0); flag_low = (i % 2 == 1);
            step();
        end
        flag_high = 1'b0; flag_low = 1'b0;
        checks++; if (data_miso !== 8'h3C) begin errors++; $display("FAIL abort_data_miso got %h exp 3c", data_miso); end
        ss = 1'b0;
        step();
    endtask

    task automatic test_mode3();
        logic [7:0] tx, rx;
        tx = 8'h81; rx = 8'h0F;
        start(tx, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            flag_low = 1'b1; step(); flag_low = 1'b0;
            checks++; if (mosi !== tx[i]) begin errors++; $display("FAIL m3_mosi bit%0d got %b exp %b", i, mosi, tx[i]); end
            miso = rx[i]; flag_high = 1'b1; step(); flag_high = 1'b0;
            if (i < 7) begin
                checks++; if (mosi !== tx[i]) begin errors++; $display("FAIL m3_mosi_hold bit%0d got %b exp %b", i, mosi, tx[i]); end
            end
        end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL m3_rx_valid got %b exp 1", rx_valid); end
        checks++; if (data_miso !== 8'h0F) begin errors++; $display("FAIL m3_data_miso got %h exp 0f", data_miso); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL m3_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_overlap();
        start(8'h00, 1'b0, 1'b0, 1'b0);
        data_mosi = 8'hFF; send_data = 1'b1; miso = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL ovl_mosi bit%0d got %b exp 0", i, mosi); end
            flag_high = 1'b1; step(); flag_high = 1'b0;
            if (i < 7) begin
                flag_low = 1'b1; step(); flag_low = 1'b0;
            end
        end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovl_rx_valid got %b exp 1", rx_valid); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovl_busy_idle got %b exp 0", busy); end
        step();
        send_data = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovl_new_busy got %b exp 1", busy); end
        checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL ovl_new_mosi got %b exp 1", mosi); end
        ss = 1'b1; step(); ss = 1'b0; step();
    endtask

    task automatic test_reset_mid();
        start(8'hC3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            flag_high = 1'b1; step(); flag_high = 1'b0;
            flag_low = 1'b1; step(); flag_low = 1'b0;
        end
        #2 PRESETn = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL rmid_mosi got %b exp 0", mosi); end
        checks++; if (data_miso !== 8'h00) begin errors++; $display("FAIL rmid_data_miso got %h exp 00", data_miso); end
        for (int i = 0; i < 6; i++) begin
            flag_high = (i % 2 == 0); flag_low = (i % 2 == 1);
            step();
            checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rmid_rx_valid_in cyc%0d got %b exp 0", i, rx_valid); end
            if (i == 3) PRESETn = 1'b1;
        end
        flag_high = 1'b0; flag_low = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy_after got %b exp 0", busy); end
        start(8'h80, 1'b0, 1'b0, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_first_load got %b exp 1", busy); end
        ss = 1'b1; step(); ss = 1'b0; step();
    endtask

    task automatic test_guards();
        logic [7:0] rx;
        rx = 8'h5A;
        flag_high = 1'b1; step(); flag_high = 1'b0;
        flag_low = 1'b1; step(); flag_low = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL grd_idle_busy got %b exp 0", busy); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL grd_idle_mosi got %b exp 0", mosi); end
        start(8'h80, 1'b0, 1'b0, 1'b0);
        flag_high = 1'b1; flag_low = 1'b1; step();
        flag_high = 1'b1; flag_low = 1'b1; step();
        flag_high = 1'b0; flag_low = 1'b0;
        checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL grd_both_mosi got %b exp 1", mosi); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL grd_both_busy got %b exp 1", busy); end
        for (int i = 0; i < 8; i++) begin
            miso = rx[7-i]; flag_high = 1'b1; step(); flag_high = 1'b0;
            if (i < 7) begin
                checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL grd_early_rx_valid bit%0d got %b exp 0", i, rx_valid); end
                flag_low = 1'b1; step(); flag_low = 1'b0;
            end
        end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL grd_rx_valid got %b exp 1", rx_valid); end
        checks++; if (data_miso !== 8'h5A) begin errors++; $display("FAIL grd_data_miso got %h exp 5a", data_miso); end
        step();
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_abort();
        test_mode3();
        test_overlap();
        test_reset_mid();
        test_guards();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
